// File: rtl/aes128_encrypt_ctrl_if.sv
// aes128_encrypt_ctrl_if: block-in / ciphertext-out handshake bundle for the AES-128 controller.
interface aes128_encrypt_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
    logic [3:0]   round_idx;
    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext, busy, round_idx
    );
    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext, busy, round_idx
    );
endinterface

// File: rtl/aes128_encrypt_ctrl.sv
// aes128_encrypt_ctrl: iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x = p;
        for (int i = 0; i < 8; i++) begin
            acc = q[i] ? acc ^ x : acc;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction
    // Inverse as a^254 in GF(2^8); zero maps to zero, matching the S-box definition.
    logic [7:0] a3, a7, a15, a31, a63, a127, inv;
    assign a3   = gmul(gmul(a, a), a);
    assign a7   = gmul(gmul(a3, a3), a);
    assign a15  = gmul(gmul(a7, a7), a);
    assign a31  = gmul(gmul(a15, a15), a);
    assign a63  = gmul(gmul(a31, a31), a);
    assign a127 = gmul(gmul(a63, a63), a);
    assign inv  = gmul(a127, a127);
    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes_sub_shift (
    input  logic [127:0] d,
    output logic [127:0] q
);
    logic [7:0] sb [16];
    for (genvar i = 0; i < 16; i++) begin : g_sb
        aes_sbox u_sbox (.a(d[127-8*i -: 8]), .y(sb[i]));
        assign q[127-8*i -: 8] = sb[4*(((i/4) + (i%4)) % 4) + (i%4)];
    end
endmodule

module aes_round (
    input  logic [127:0] state,
    input  logic [127:0] rkey,
    output logic [127:0] q
);
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction
    logic [127:0] ss;
    aes_sub_shift u_ss (.d(state), .q(ss));
    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] b0, b1, b2, b3;
        assign {b0, b1, b2, b3} = ss[127-32*c -: 32];
        assign q[127-32*c -: 32] = {
            xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3,
            b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3,
            b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3,
            xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3)
        } ^ rkey[127-32*c -: 32];
    end
endmodule

module aes128_encrypt_ctrl #(
    parameter int NR = 10
) (
    input logic clk,
    input logic reset,
    aes128_encrypt_ctrl_if.slave bus
);
    if (NR != 10) begin : g_nr_check
        $error("aes128_encrypt_ctrl supports NR=10 only");
    end
    localparam logic [3:0] LAST = 4'(NR);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, rkey_q, nk, mid, fin_ss;
    logic [7:0]   rcon_q;
    logic [3:0]   ctr_q;
    logic [31:0]  sub_w, t;
    // RotWord is folded into the S-box wiring: output byte i reads w3 byte (i+1)%4.
    for (genvar i = 0; i < 4; i++) begin : g_ks
        aes_sbox u_sbox (.a(rkey_q[31-8*((i+1)%4) -: 8]), .y(sub_w[31-8*i -: 8]));
    end
    assign t = sub_w ^ {rcon_q, 24'h0};
    assign nk[127:96] = rkey_q[127:96] ^ t;
    assign nk[95:64]  = rkey_q[95:64] ^ nk[127:96];
    assign nk[63:32]  = rkey_q[63:32] ^ nk[95:64];
    assign nk[31:0]   = rkey_q[31:0] ^ nk[63:32];
    aes_round     u_round (.state(state_q), .rkey(nk), .q(mid));
    aes_sub_shift u_final (.d(state_q), .q(fin_ss));
    always_ff @(posedge clk) fsm_q <= reset ? IDLE : fsm_d;
    always_comb begin
        fsm_d = (fsm_q == IDLE && bus.in_valid) ? ROUND :
                (fsm_q == ROUND && ctr_q == LAST) ? DONE :
                (fsm_q == DONE && bus.out_ready) ? IDLE : fsm_q;
    end
    always_comb begin
        bus.in_ready   = fsm_q == IDLE;
        bus.busy       = fsm_q == ROUND || fsm_q == DONE;
        bus.out_valid  = fsm_q == DONE;
        bus.round_idx  = fsm_q == IDLE ? 4'd0 : ctr_q;
        bus.ciphertext = state_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            rkey_q  <= '0;
            rcon_q  <= '0;
            ctr_q   <= '0;
        end else if (fsm_q == IDLE && bus.in_valid) begin
            state_q <= bus.plaintext ^ bus.key;
            rkey_q  <= bus.key;
            rcon_q  <= 8'h01;
            ctr_q   <= 4'd1;
        end else if (fsm_q == ROUND) begin
            rkey_q  <= nk;
            rcon_q  <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            state_q <= ctr_q < LAST ? mid : fin_ss ^ nk;
            ctr_q   <= ctr_q == LAST ? ctr_q : ctr_q + 4'd1;
        end
    end
endmodule

// File: doc/aes128_encrypt_ctrl.md
# aes128_encrypt_ctrl

Iterative AES-128 encryption controller built around the existing combinational `Round` unit (SubBytes, ShiftRows, MixColumns, AddRoundKey). It accepts a plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey. It then reuses one `Round` instance for rounds 1–9 and a local final round for round 10, expanding round keys on the fly, one round per clock. The ciphertext is presented over a valid/ready handshake. It sits between the host interface and any block-mode logic, such as a future ECB/CTR wrapper.

## Interface
- `NR`, default 10: round count. Only 10 is legal; any other value is a synthesis-time error.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: one clock; reset is synchronous and active-high.
- `in_valid` input 1: plaintext/key present.
- `in_ready` output 1: controller can accept a block; high only in IDLE.
- `plaintext` input 128: input block, FIPS-197 byte order (MSB = byte 0).
- `key` input 128: cipher key, same byte order.
- `out_valid` output 1: ciphertext valid.
- `out_ready` input 1: consumer takes ciphertext.
- `ciphertext` output 128: result, driven directly from the state register.
- `busy` output 1: high in ROUND or DONE.
- `round_idx` output 4: current round counter (0 in IDLE, 1..10 in ROUND, 10 in DONE).

## Operation
- Registers:
  - `state_q` (128)
  - `rkey_q` (128): previous round key
  - `rcon_q` (8)
  - `ctr_q` (4)
  - 2-bit FSM: IDLE, ROUND, DONE
- IDLE → ROUND when `in_valid && in_ready`:
  - `state_q <= plaintext ^ key`
  - `rkey_q <= key`
  - `rcon_q <= 8'h01`
  - `ctr_q <= 1`
- ROUND, each cycle:
  - Key step: `nk = expand(rkey_q, rcon_q)`. With words w0..w3 (w0 = bits 127:96): `t = SubWord(RotWord(w3)) ^ {rcon_q,24'h0}`; `n0 = w0^t`, `n1 = w1^n0`, `n2 = w2^n1`, `n3 = w3^n2`.
  - `rkey_q <= nk`.
  - `rcon_q <= xtime(rcon_q)`, where `xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 0)`. Sequence: 01,02,04,08,10,20,40,80,1b,36.
  - If `ctr_q < 10`: `state_q <= Round(state_q, nk)`. Else: `state_q <= ShiftRows(SubBytes(state_q)) ^ nk` (no MixColumns).
  - If `ctr_q == 10` → DONE, else `ctr_q <= ctr_q + 1`.
- DONE: `out_valid = 1`; hold `ciphertext` stable until `out_ready`; on `out_valid && out_ready` → IDLE.
- `Round` is instantiated unchanged. Final-round and SubWord S-box lookups reuse the codebase's S-box unit (20 S-boxes: 16 final-round + 4 key-schedule).
- `in_valid` while `busy`: ignored; `plaintext`/`key` are not sampled, and the in-flight block is unaffected.
- `plaintext`/`key` must be valid only in the accept cycle; they are not re-read afterwards.

## Timing
- Reset (any state, including mid-round): FSM = IDLE, all registers zero, outputs as follows:
  - `in_ready=1`
  - `out_valid=0`
  - `busy=0`
  - `round_idx=0`
  - `ciphertext=0`

  The aborted block produces no output.
- Accept at edge E0; rounds update at edges E1..E10; `out_valid` is high from the cycle after E10. Latency from accept edge to `out_valid` is 10 cycles.
- Output handshake: a transfer occurs at the edge where `out_valid && out_ready`. With `out_ready` held high, DONE lasts 1 cycle and IDLE/`in_ready` returns the next cycle. Minimum block period is 12 cycles.
- `out_ready` low: DONE holds indefinitely with `ciphertext` unchanged.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`; all outputs are registered or FSM-decoded.
- Critical path: one `Round` plus the key-expansion XOR chain, in parallel; one round per cycle.

## Test plan
- FIPS-197 App. B: pt `3243f6a8885a308d313198a2e0370734`, key `2b7e151628aed2a6abf7158809cf4f3c`.
  - Expected intermediates: after accept `state_q = 193de3bea0f4e22b9ac68d2ae9f84808`; after E1 `a49c7ff2689f352b6b5bea43026a5049` with `rkey_q = a0fafe1788542cb123a339392a6c7605`; after E2 `aa8f5f0361dde3ef82d24ad26832469a`.
  - Final: `ciphertext = 3925841d02dc09fbdc118597196a0b32` exactly 10 cycles after accept; `rkey_q = d014f9a8c9ee2589e13f0cc8b6630ca6`.
- FIPS-197 C.1: pt `00112233445566778899aabbccddeeff`, key `000102030405060708090a0b0c0d0e0f` → `69c4e0d86a7b0430d8cdb78070b4c55a`.
- Backpressure: `out_ready=0` for 20 cycles after `out_valid` → `ciphertext`, `out_valid=1` and `in_ready=0` stable. Raising `out_ready` completes the transfer in 1 cycle and `in_ready=1` the next cycle.
- Busy input: assert `in_valid` with a different pt/key at round 5 → no effect; App. B result unchanged.
- Reset mid-operation: assert `reset` at `round_idx=6` → next cycle all outputs at reset values. Then run C.1 → correct ciphertext.
- Back-to-back: App. B then C.1 with `in_valid` and `out_ready` held high → both results correct, 12-cycle spacing between accepts.
